// File: rtl/msg_arb_queue_if.sv
// Producer/consumer bundle for msg_arb_queue: per-channel write requests,
// FWFT read port and buffer status.
interface msg_arb_queue_if #(
  parameter int MSG_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter int CHANNELS   = 4,
  parameter int CH_BITS    = 2
);
  logic [CHANNELS*MSG_WIDTH-1:0] write;
  logic [CHANNELS-1:0]           write_en;
  logic [CHANNELS-1:0]           write_ack;
  logic [MSG_WIDTH-1:0]          read;
  logic [CH_BITS-1:0]            read_src;
  logic                          read_valid;
  logic                          read_ack;
  logic [DEPTH_LOG2:0]           count;
  logic                          full;
  logic                          almost_full;
  logic                          empty;

  modport master (
    output write, write_en, read_ack,
    input  write_ack, read, read_src, read_valid, count, full, almost_full, empty
  );

  modport slave (
    input  write, write_en, read_ack,
    output write_ack, read, read_src, read_valid, count, full, almost_full, empty
  );
endinterface

// File: rtl/msg_arb_queue.sv
// Shared circular message buffer fed by a round-robin arbiter over CHANNELS
// producers, drained through a first-word-fall-through read port.
module msg_arb_queue #(
  parameter int MSG_WIDTH   = 16,
  parameter int DEPTH_LOG2  = 3,
  parameter int CHANNELS    = 4,
  parameter int CH_BITS     = 2,
  parameter int ALMOST_FULL = 6
) (
  input  logic           clock,
  input  logic           reset,
  msg_arb_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_AF   = (DEPTH_LOG2+1)'(ALMOST_FULL);

  logic [CH_BITS+MSG_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]        q_in;
  logic [DEPTH_LOG2-1:0]        q_out;
  logic [DEPTH_LOG2:0]          count;
  logic [CH_BITS-1:0]           last_grant;

  logic [CH_BITS-1:0]   winner;
  logic [CH_BITS-1:0]   hi_ch;
  logic [CH_BITS-1:0]   lo_ch;
  logic                 hi_hit;
  logic                 lo_hit;
  logic                 have_winner;
  logic [MSG_WIDTH-1:0] win_msg;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign full = (count == CNT_FULL);

  // Round-robin: the lowest requester above last_grant wins; otherwise wrap
  // around to the lowest requester at or below it.
  always_comb begin
    hi_hit  = 1'b0;
    lo_hit  = 1'b0;
    hi_ch   = '0;
    lo_ch   = '0;
    win_msg = '0;
    for (int c = CHANNELS-1; c >= 0; c--) begin
      if (bus.write_en[c]) begin
        if (c > int'(last_grant)) begin
          hi_hit = 1'b1;
          hi_ch  = CH_BITS'(c);
        end else begin
          lo_hit = 1'b1;
          lo_ch  = CH_BITS'(c);
        end
      end
    end
    have_winner = hi_hit | lo_hit;
    winner      = hi_hit ? hi_ch : lo_ch;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CH_BITS'(c) == winner) win_msg = bus.write[c*MSG_WIDTH +: MSG_WIDTH];
    end
  end

  // A full buffer still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop           = bus.read_ack && (count != '0) && !reset;
    push          = have_winner && (!full || bus.read_ack) && !reset;
    bus.write_ack = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.write_ack[c] = push && (winner == CH_BITS'(c));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_in       <= '0;
      q_out      <= '0;
      count      <= '0;
      last_grant <= CH_BITS'(CHANNELS-1);
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[q_in]  <= {winner, win_msg};
        q_in       <= q_in + 1'b1;
        last_grant <= winner;
      end
      if (pop) q_out <= q_out + 1'b1;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  assign bus.read        = mem[q_out][MSG_WIDTH-1:0];
  assign bus.read_src    = mem[q_out][CH_BITS+MSG_WIDTH-1:MSG_WIDTH];
  assign bus.read_valid  = (count != '0);
  assign bus.empty       = (count == '0);
  assign bus.full        = full;
  assign bus.almost_full = (count >= CNT_AF);
  assign bus.count       = count;
endmodule

// File: tb/tb_msg_arb_queue.sv
// Directed bench for msg_arb_queue: stimulus pushes expected messages into a
// scoreboard, a monitor checks every popped head against it.
module tb_msg_arb_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;

  msg_arb_queue_if #(.MSG_WIDTH(16), .DEPTH_LOG2(3), .CHANNELS(4), .CH_BITS(2)) bus ();

  msg_arb_queue #(
    .MSG_WIDTH(16), .DEPTH_LOG2(3), .CHANNELS(4), .CH_BITS(2), .ALMOST_FULL(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] msg;
  } entry_t;

  entry_t      exp_q[$];
  logic [15:0] wdata [4];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clock = ~clock;

  assign bus.write = {wdata[3], wdata[2], wdata[1], wdata[0]};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input int cnt, input logic af, input logic fl);
    check_output({name, "_count"}, 32'(bus.count), 32'(cnt));
    check_output({name, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
    check_output({name, "_valid"}, 32'(bus.read_valid), 32'(cnt != 0));
    check_output({name, "_afull"}, 32'(bus.almost_full), 32'(af));
    check_output({name, "_full"}, 32'(bus.full), 32'(fl));
  endtask

  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic apply_stimulus(input logic [3:0] en, input logic ack, input logic [3:0] exp_ack);
    entry_t e;
    bus.write_en = en;
    bus.read_ack = ack;
    @(negedge clock);
    check_output("write_ack", 32'(bus.write_ack), 32'(exp_ack));
    for (int c = 0; c < 4; c++) begin
      if (exp_ack[c]) begin
        e.src = 2'(c);
        e.msg = wdata[c];
        exp_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    entry_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.read_valid && bus.read_ack) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL pop_unexpected: got %0h from ch%0d, expected nothing", bus.read, bus.read_src);
        end else begin
          e = exp_q.pop_front();
          check_output("pop_msg", 32'(bus.read), 32'(e.msg));
          check_output("pop_src", 32'(bus.read_src), 32'(e.src));
        end
      end
    end
  end

  initial begin
    bus.write_en = '0;
    bus.read_ack = 1'b0;
    for (int c = 0; c < 4; c++) wdata[c] = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    bus.write_en = 4'b1111;
    #1;
    check_status("rst", 0, 1'b0, 1'b0);
    check_output("rst_write_ack", 32'(bus.write_ack), 32'h0);
    check_output("rst_read", 32'(bus.read), 32'h0);
    check_output("rst_src", 32'(bus.read_src), 32'h0);
    bus.write_en = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // One message in flight, then asynchronous reset mid-cycle
    wdata[0] = 16'h0AAA;
    apply_stimulus(4'b0001, 1'b0, 4'b0001);
    check_status("pre_rst", 1, 1'b0, 1'b0);
    bus.write_en = 4'b1111;
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_status("async_rst", 0, 1'b0, 1'b0);
    check_output("async_rst_ack", 32'(bus.write_ack), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.write_en = '0;
    for (int i = 0; i < 5; i++) apply_stimulus(4'b0000, 1'b0, 4'b0000);
    check_status("idle", 0, 1'b0, 1'b0);

    // Single channel FIFO order
    wdata[2] = 16'h0011;
    apply_stimulus(4'b0100, 1'b0, 4'b0100);
    check_status("fifo_w1", 1, 1'b0, 1'b0);
    check_output("fifo_head", 32'(bus.read), 32'h0011);
    wdata[2] = 16'h0022;
    apply_stimulus(4'b0100, 1'b0, 4'b0100);
    check_status("fifo_w2", 2, 1'b0, 1'b0);
    wdata[2] = 16'h0033;
    apply_stimulus(4'b0100, 1'b0, 4'b0100);
    check_status("fifo_w3", 3, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("fifo_r1", 2, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("fifo_r2", 1, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("fifo_r3", 0, 1'b0, 1'b0);

    // Round-robin from reset, filling to full
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) wdata[c] = 16'h1000 + 16'(c * 256) + 16'(i);
      apply_stimulus(4'b1111, 1'b0, 4'(1 << (i % 4)));
      check_status("rr_fill", i + 1, (i + 1) >= 6, (i + 1) == 8);
    end
    apply_stimulus(4'b1111, 1'b0, 4'b0000);
    check_status("full_reject", 8, 1'b1, 1'b1);

    // Push and pop together while full
    wdata[1] = 16'hBEEF;
    apply_stimulus(4'b0010, 1'b1, 4'b0010);
    check_status("full_pushpop", 8, 1'b1, 1'b1);
    check_output("pushpop_head", 32'(bus.read), 32'h1101);
    check_output("pushpop_src", 32'(bus.read_src), 32'h1);
    for (int i = 0; i < 8; i++) apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("drained", 0, 1'b0, 1'b0);

    // Pop while empty is ignored
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("empty_pop", 0, 1'b0, 1'b0);

    // Fill to five, then reset mid-cycle
    for (int i = 0; i < 5; i++) begin
      wdata[3] = 16'h3000 + 16'(i);
      apply_stimulus(4'b1000, 1'b0, 4'b1000);
    end
    check_status("fill5", 5, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_status("mid_rst", 0, 1'b0, 1'b0);
    check_output("mid_rst_read", 32'(bus.read), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wdata[2] = 16'h7777;
    apply_stimulus(4'b0100, 1'b0, 4'b0100);
    check_output("after_rst_head", 32'(bus.read), 32'h7777);
    check_output("after_rst_src", 32'(bus.read_src), 32'h2);
    apply_stimulus(4'b0000, 1'b1, 4'b0000);
    check_status("final", 0, 1'b0, 1'b0);

    bus.read_ack = 1'b0;
    check_output("scoreboard_left", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
